// File: rtl/video_pkg.sv
// Video raster package: default NTSC-style timing constants for the 32 MHz
// pixel clock, the front-end state type and a width helper.
// No ports.
package video_pkg;

  localparam int H_TOTAL_DEF = 2038;
  localparam int V_TOTAL_DEF = 262;
  localparam int HS_WID_DEF  = 150;
  localparam int VS_LIN_DEF  = 248;
  localparam int VS_WID_DEF  = 1888;
  localparam int CB_ST_DEF   = 168;
  localparam int CB_ND_DEF   = 248;
  localparam int ASTART_DEF  = 371;
  localparam int BK_TOP_DEF  = 16;
  localparam int BK_BOT_DEF  = 240;
  localparam int PIX_DIV_DEF = 6;
  localparam int COLS_DEF    = 32;
  localparam int ROWS_DEF    = 32;
  localparam int CHAR_H_DEF  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } raster_state_e;

  // Bit width able to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_raster_cnt.sv
// Horizontal/vertical raster counters with registered sync, colorburst and
// end-of-frame decodes (all decodes lag their counter condition by 1 clock).
// Ports:
//   clk, reset  pixel clock, synchronous active-high reset
//   hcnt, vcnt  raw counter values (current clock)
//   hs, vs      active-low syncs
//   cb          colorburst gate
//   frame       one-clock pulse after the last clock of a frame
module video_raster_cnt
  import video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int HS_WID  = HS_WID_DEF,
  parameter int VS_LIN  = VS_LIN_DEF,
  parameter int VS_WID  = VS_WID_DEF,
  parameter int CB_ST   = CB_ST_DEF,
  parameter int CB_ND   = CB_ND_DEF,
  localparam int HCW    = clog2w(H_TOTAL),
  localparam int VCW    = clog2w(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [HCW-1:0] hcnt,
  output logic [VCW-1:0] vcnt,
  output logic           hs,
  output logic           vs,
  output logic           cb,
  output logic           frame
);

  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic           hs_q, hs_d, vs_q, vs_d, cb_q, cb_d, frame_q, frame_d;

  always_comb begin
    hcnt_d = hcnt_q + HCW'(1);
    vcnt_d = vcnt_q;
    if (int'(hcnt_q) == H_TOTAL - 1) begin
      hcnt_d = '0;
      vcnt_d = (int'(vcnt_q) == V_TOTAL - 1) ? '0 : vcnt_q + VCW'(1);
    end
    hs_d    = !(int'(hcnt_q) < HS_WID);
    vs_d    = !(int'(vcnt_q) == VS_LIN && int'(hcnt_q) < VS_WID);
    cb_d    = (int'(hcnt_q) >= CB_ST) && (int'(hcnt_q) < CB_ND);
    frame_d = (int'(hcnt_q) == H_TOTAL - 1) && (int'(vcnt_q) == V_TOTAL - 1);
  end

  // counter / decode register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b1;
      cb_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      cb_q    <= cb_d;
      frame_q <= frame_d;
    end
  end

  assign hcnt  = hcnt_q;
  assign vcnt  = vcnt_q;
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign cb    = cb_q;
  assign frame = frame_q;

endmodule

// File: rtl/video_raster.sv
// Parametrised raster timing and text-address generator.
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   scroll_y        vertical scroll in lines, taken once per frame
//   line_cmp        active-line index for the line interrupt
//   irq_ena/irq_ack line interrupt enable / clear (set wins over clear)
//   hs, vs, cb      active-low syncs and colorburst gate
//   active          active display window
//   pixena, vload   pixel strobe and shift-register load strobe
//   haddr           character column
//   cline, vaddr    line within character, character row
//   frame           one-clock pulse per frame
//   irq             sticky line interrupt
module video_raster
  import video_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int HS_WID  = HS_WID_DEF,
  parameter int VS_LIN  = VS_LIN_DEF,
  parameter int VS_WID  = VS_WID_DEF,
  parameter int CB_ST   = CB_ST_DEF,
  parameter int CB_ND   = CB_ND_DEF,
  parameter int ASTART  = ASTART_DEF,
  parameter int BK_TOP  = BK_TOP_DEF,
  parameter int BK_BOT  = BK_BOT_DEF,
  parameter int PIX_DIV = PIX_DIV_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int CHAR_H  = CHAR_H_DEF,
  localparam int CW     = clog2w(COLS),
  localparam int RW     = clog2w(ROWS),
  localparam int LW     = clog2w(CHAR_H),
  localparam int SW     = RW + LW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] scroll_y,
  input  logic [8:0]    line_cmp,
  input  logic          irq_ena,
  input  logic          irq_ack,
  output logic          hs,
  output logic          vs,
  output logic          cb,
  output logic          active,
  output logic          pixena,
  output logic          vload,
  output logic [CW-1:0] haddr,
  output logic [LW-1:0] cline,
  output logic [RW-1:0] vaddr,
  output logic          frame,
  output logic          irq
);

  localparam int HCW = clog2w(H_TOTAL);
  localparam int VCW = clog2w(V_TOTAL);
  localparam int DW  = clog2w(PIX_DIV);

  // The whole window must end inside the line so the idle state is always
  // re-entered before the next line's start column.
  if (ASTART + COLS * 8 * PIX_DIV >= H_TOTAL) begin : g_bad_window
    $error("video_raster: active window does not fit in H_TOTAL");
  end

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;

  video_raster_cnt #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HS_WID  (HS_WID),
    .VS_LIN  (VS_LIN),
    .VS_WID  (VS_WID),
    .CB_ST   (CB_ST),
    .CB_ND   (CB_ND)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .hcnt  (hcnt),
    .vcnt  (vcnt),
    .hs    (hs),
    .vs    (vs),
    .cb    (cb),
    .frame (frame)
  );

  raster_state_e  state_q, state_d;
  logic           pixena_q, pixena_d, vload_q, vload_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic [2:0]     pcnt_q, pcnt_d;
  logic [CW-1:0]  haddr_q, haddr_d;
  logic [SW-1:0]  addr_q, addr_d;
  logic [SW-1:0]  scroll_q, scroll_d;
  logic           irq_q, irq_d;
  logic           at_start, frame_last, irq_hit;

  always_comb begin
    at_start   = (int'(hcnt) == ASTART) && (int'(vcnt) >= BK_TOP) && (int'(vcnt) < BK_BOT);
    frame_last = (int'(hcnt) == H_TOTAL - 1) && (int'(vcnt) == V_TOTAL - 1);
    // Signed arithmetic keeps lines above the window from aliasing onto a
    // large line_cmp value.
    irq_hit    = irq_ena && (hcnt == '0) && (int'(vcnt) >= BK_TOP)
                 && ((int'(vcnt) - BK_TOP) == int'(line_cmp))
                 && (int'(line_cmp) < BK_BOT - BK_TOP);

    state_d  = state_q;
    pixena_d = 1'b0;
    vload_d  = 1'b0;
    dcnt_d   = dcnt_q;
    pcnt_d   = pcnt_q;
    haddr_d  = haddr_q;
    addr_d   = addr_q;
    scroll_d = frame_last ? scroll_y : scroll_q;

    if (irq_hit) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (at_start) begin
          state_d  = ST_RUN;
          pixena_d = 1'b1;
          vload_d  = 1'b1;
          dcnt_d   = '0;
          pcnt_d   = '0;
          haddr_d  = '0;
          if (int'(vcnt) == BK_TOP) begin
            addr_d = scroll_q;
          end
        end
      end
      ST_RUN: begin
        if (int'(dcnt_q) == PIX_DIV - 1) begin
          dcnt_d  = '0;
          pcnt_d  = pcnt_q + 3'd1;
          if (pcnt_q == 3'd7) begin
            haddr_d = haddr_q + CW'(1);
            if (int'(haddr_q) == COLS - 1) begin
              state_d = ST_IDLE;
              addr_d  = addr_q + SW'(1);
            end else begin
              pixena_d = 1'b1;
              vload_d  = 1'b1;
            end
          end else begin
            pixena_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // window / address / interrupt register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pixena_q <= 1'b0;
      vload_q  <= 1'b0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      haddr_q  <= '0;
      addr_q   <= '0;
      scroll_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pixena_q <= pixena_d;
      vload_q  <= vload_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      haddr_q  <= haddr_d;
      addr_q   <= addr_d;
      scroll_q <= scroll_d;
      irq_q    <= irq_d;
    end
  end

  assign active = (state_q == ST_RUN);
  assign pixena = pixena_q;
  assign vload  = vload_q;
  assign haddr  = haddr_q;
  assign cline  = addr_q[LW-1:0];
  assign vaddr  = addr_q[SW-1:LW];
  assign irq    = irq_q;

endmodule

// File: tb/tb_video_raster.sv
// Bench for video_raster with a scaled-down raster so several frames fit in
// a short run. A behavioural model derives every output from the elapsed
// clock count since reset; a few literal expectations pin that model.
module tb_video_raster;

  localparam int H   = 100;
  localparam int V   = 20;
  localparam int HSW = 10;
  localparam int VSL = 17;
  localparam int VSW = 80;
  localparam int CBS = 12;
  localparam int CBN = 18;
  localparam int AST = 20;
  localparam int BKT = 3;
  localparam int BKB = 15;
  localparam int PD  = 2;
  localparam int NC  = 4;
  localparam int NR  = 4;
  localparam int CH  = 4;
  localparam int WIN   = NC * 8 * PD;
  localparam int NADDR = NR * CH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] scroll_y = '0;
  logic [8:0] line_cmp = '0;
  logic       irq_ena = 1'b0;
  logic       irq_ack = 1'b0;
  logic       hs, vs, cb, active, pixena, vload, frame, irq;
  logic [1:0] haddr, cline, vaddr;

  video_raster #(
    .H_TOTAL (H),   .V_TOTAL (V),   .HS_WID (HSW), .VS_LIN (VSL),
    .VS_WID  (VSW), .CB_ST   (CBS), .CB_ND  (CBN), .ASTART (AST),
    .BK_TOP  (BKT), .BK_BOT  (BKB), .PIX_DIV(PD),  .COLS   (NC),
    .ROWS    (NR),  .CHAR_H  (CH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scroll_y (scroll_y),
    .line_cmp (line_cmp),
    .irq_ena  (irq_ena),
    .irq_ack  (irq_ack),
    .hs       (hs),
    .vs       (vs),
    .cb       (cb),
    .active   (active),
    .pixena   (pixena),
    .vload    (vload),
    .haddr    (haddr),
    .cline    (cline),
    .vaddr    (vaddr),
    .frame    (frame),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // Model state: clocks since reset, scroll value latched at frame end,
  // sticky interrupt.
  int   ncnt = 0;
  int   mscroll = 0;
  logic mirq = 1'b0;
  bit   check_en = 1'b0;

  always @(posedge clk) begin : model
    int h, v;
    h = ncnt % H;
    v = (ncnt / H) % V;
    if (reset) begin
      ncnt    <= 0;
      mscroll <= 0;
      mirq    <= 1'b0;
    end else begin
      ncnt <= ncnt + 1;
      if (h == H - 1 && v == V - 1) mscroll <= int'(scroll_y);
      if (irq_ena && h == 0 && v >= BKT && v - BKT == int'(line_cmp) && int'(line_cmp) < BKB - BKT)
        mirq <= 1'b1;
      else if (irq_ack)
        mirq <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    int m, h, v, t, a;
    logic e_hs, e_vs, e_cb, e_act, e_pix, e_vl, e_fr;
    int e_ha, e_cl, e_va;
    if (check_en) begin
      if (ncnt == 0) begin
        e_hs = 0; e_vs = 1; e_cb = 0; e_act = 0; e_pix = 0; e_vl = 0; e_fr = 0;
        e_ha = 0; e_cl = 0; e_va = 0;
      end else begin
        m = ncnt - 1;
        h = m % H;
        v = (m / H) % V;
        t = h - AST;
        e_hs  = (h >= HSW);
        e_vs  = !(v == VSL && h < VSW);
        e_cb  = (h >= CBS && h < CBN);
        e_fr  = (h == H - 1 && v == V - 1);
        e_act = (v >= BKT && v < BKB && t >= 0 && t < WIN);
        e_pix = e_act && (t % PD == 0);
        e_vl  = e_act && (t % (8 * PD) == 0);
        e_ha  = e_act ? t / (8 * PD) : 0;
        a     = (mscroll + v - BKT) % NADDR;
        e_cl  = a % CH;
        e_va  = a / CH;
      end
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("cb", cb, e_cb);
      chk("frame", frame, e_fr);
      chk("active", active, e_act);
      chk("pixena", pixena, e_pix);
      chk("vload", vload, e_vl);
      chk("haddr", haddr, e_ha);
      chk("irq", irq, mirq);
      if (e_act || ncnt == 0) begin
        chk("cline", cline, e_cl);
        chk("vaddr", vaddr, e_va);
      end
    end
  end

  task automatic wait_n(input int target);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (ncnt == target) return;
    end
    errors++;
    $display("FAIL wait_n timeout target=%0d got=%0d", target, ncnt);
  endtask

  initial begin
    int npix, nvl;
    @(posedge clk);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    line_cmp = 9'd2;
    irq_ena  = 1'b1;

    wait_n(10);  chk("lit_hs_low", hs, 0);
    wait_n(11);  chk("lit_hs_high", hs, 1);
    wait_n(320); chk("lit_act_before", active, 0);
    npix = 0;
    nvl  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      npix += int'(pixena);
      nvl  += int'(vload);
      if (ncnt == 321) begin
        chk("lit_act_rise", active, 1);
        chk("lit_first_pix", pixena, 1);
        chk("lit_first_vload", vload, 1);
        chk("lit_first_col", haddr, 0);
        chk("lit_first_cline", cline, 0);
      end
      if (ncnt == 337) begin
        chk("lit_vload_col1", vload, 1);
        chk("lit_haddr_col1", haddr, 1);
      end
    end
    chk("lit_pix_per_line", npix, 32);
    chk("lit_vload_per_line", nvl, 4);
    wait_n(421);  chk("lit_line4_cline", cline, 1);
    wait_n(500);  chk("lit_irq_before", irq, 0);
    wait_n(501);  chk("lit_irq_rise", irq, 1);
    wait_n(1000); scroll_y = 4'hB;
    wait_n(1499); irq_ack = 1'b1;
    wait_n(1500); chk("lit_irq_ack", irq, 0); irq_ack = 1'b0;
    wait_n(1999); chk("lit_frame_before", frame, 0);
    wait_n(2000); chk("lit_frame_pulse", frame, 1);
    wait_n(2321); chk("lit_scroll_vaddr", vaddr, 2); chk("lit_scroll_cline", cline, 3);
    wait_n(2500); chk("lit_irq_clear", irq, 0); irq_ack = 1'b1;
    wait_n(2501); chk("lit_set_beats_ack", irq, 1); irq_ack = 1'b0;
    wait_n(2502); chk("lit_irq_sticky", irq, 1);
    wait_n(2821); chk("lit_wrap_vaddr", vaddr, 0); chk("lit_wrap_cline", cline, 0);
    chk("lit_wrap_active", active, 1);

    for (int k = 0; k < 16000; k++) begin
      @(negedge clk);
      irq_ack = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) scroll_y = 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        line_cmp = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 16));
        irq_ena  = ($urandom_range(0, 3) != 0);
      end
      if (k == 7000 + 37) reset = 1'b1;
      if (k == 7002 + 37) reset = 1'b0;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
